// File: rtl/cnn_pkg.sv
// cnn_pkg: shared types and widths for the channel sequencer.
package cnn_pkg;

    localparam int DEF_SPAD_DATA_WIDTH = 64;
    localparam int DEF_ADDR_WIDTH      = 8;
    localparam int OFMAP_CNT_WIDTH     = 16;

    localparam logic SPAD_SEL_WEIGHT = 1'b0;
    localparam logic SPAD_SEL_INPUT  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD_K,
        LOAD_I,
        ARM,
        ROUTE,
        DONE
    } seq_state_t;

endpackage

// File: rtl/channel_sequencer_route_watchdog.sv
// route_watchdog: counts cycles from start and flags expiry after TIMEOUT_CYCLES.
module route_watchdog #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    input  logic i_clear,
    output logic o_expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic          run;
    logic [CW-1:0] cnt;

    assign o_expire = run && cnt == CW'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            run <= 1'b0;
            cnt <= '0;
        end else if (i_clear || o_expire) begin
            run <= 1'b0;
            cnt <= '0;
        end else if (i_start) begin
            run <= 1'b1;
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/channel_sequencer.sv
// channel_sequencer: per-layer controller that loads SPADs, arms routing and tracks core completion.
module channel_sequencer
    import cnn_pkg::*;
#(
    parameter int SPAD_DATA_WIDTH = DEF_SPAD_DATA_WIDTH,
    parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int ARM_CYCLES      = 2,
    parameter int TIMEOUT_CYCLES  = 4096
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic [ADDR_WIDTH-1:0]      i_num_ch,
    input  logic [ADDR_WIDTH-1:0]      i_k_words,
    input  logic [ADDR_WIDTH-1:0]      i_if_words,
    input  logic                       i_ld_valid,
    input  logic [SPAD_DATA_WIDTH-1:0] i_ld_data,
    output logic                       o_ld_ready,
    output logic                       o_write_en,
    output logic                       o_spad_select,
    output logic [ADDR_WIDTH-1:0]      o_write_addr,
    output logic [SPAD_DATA_WIDTH-1:0] o_data_in,
    output logic [ADDR_WIDTH-1:0]      o_i_addr_end,
    output logic [ADDR_WIDTH-1:0]      o_c,
    output logic                       o_reg_clear,
    output logic                       o_route_en,
    input  logic                       i_core_done,
    input  logic                       i_ofmap_valid,
    output logic [OFMAP_CNT_WIDTH-1:0] o_ofmap_count,
    output logic                       o_ch_done,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_error
);

    localparam int AW = ADDR_WIDTH;

    seq_state_t    state;
    logic [AW-1:0] num_ch;
    logic [AW-1:0] k_words;
    logic [AW-1:0] if_words;
    logic [AW-1:0] cnt;
    logic [AW-1:0] words;
    logic          hs;
    logic          last_word;
    logic          arm_last;
    logic          last_ch;
    logic          route_done;
    logic          expire;
    seq_state_t    first_load;

    assign o_busy      = state != IDLE;
    assign o_reg_clear = state == CLEAR;
    assign o_route_en  = state == ROUTE;
    assign o_ld_ready  = state == LOAD_K || (state == LOAD_I && if_words != '0);
    assign hs          = o_ld_ready && i_ld_valid;
    assign words       = state == LOAD_K ? k_words : if_words;
    assign last_word   = cnt == words - AW'(1);
    assign arm_last    = cnt == AW'(ARM_CYCLES - 1);
    assign last_ch     = o_c == num_ch - AW'(1);
    assign route_done  = state == ROUTE && i_core_done;
    assign first_load  = k_words != '0 ? LOAD_K : LOAD_I;

    route_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (state == ARM && arm_last),
        .i_clear (route_done),
        .o_expire(expire)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= IDLE;
            num_ch        <= '0;
            k_words       <= '0;
            if_words      <= '0;
            cnt           <= '0;
            o_write_en    <= 1'b0;
            o_spad_select <= SPAD_SEL_WEIGHT;
            o_write_addr  <= '0;
            o_data_in     <= '0;
            o_i_addr_end  <= '0;
            o_c           <= '0;
            o_ofmap_count <= '0;
            o_ch_done     <= 1'b0;
            o_done        <= 1'b0;
            o_error       <= 1'b0;
        end else begin
            o_write_en <= hs;
            o_ch_done  <= route_done;
            o_done     <= state == DONE;
            if (hs) begin
                o_write_addr <= cnt;
                o_data_in    <= i_ld_data;
            end
            // select is registered so it lines up with the delayed write it tags
            if (state == LOAD_K)
                o_spad_select <= SPAD_SEL_WEIGHT;
            else if (state == LOAD_I)
                o_spad_select <= SPAD_SEL_INPUT;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        num_ch        <= i_num_ch;
                        k_words       <= i_k_words;
                        if_words      <= i_if_words;
                        o_i_addr_end  <= i_if_words == '0 ? '0 : i_if_words - AW'(1);
                        o_c           <= '0;
                        cnt           <= '0;
                        o_ofmap_count <= '0;
                        o_error       <= 1'b0;
                        state         <= i_num_ch == '0 ? DONE : CLEAR;
                    end
                end
                CLEAR: state <= first_load;
                LOAD_K, LOAD_I: begin
                    if (state == LOAD_I && if_words == '0) begin
                        state <= ARM;
                    end else if (hs) begin
                        cnt <= last_word ? '0 : cnt + AW'(1);
                        if (last_word)
                            state <= state == LOAD_K ? LOAD_I : ARM;
                    end
                end
                ARM: begin
                    cnt <= arm_last ? '0 : cnt + AW'(1);
                    if (arm_last)
                        state <= ROUTE;
                end
                ROUTE: begin
                    if (i_ofmap_valid && o_ofmap_count != '1)
                        o_ofmap_count <= o_ofmap_count + OFMAP_CNT_WIDTH'(1);
                    if (route_done) begin
                        o_c   <= last_ch ? o_c : o_c + AW'(1);
                        state <= last_ch ? DONE : first_load;
                    end else if (expire) begin
                        o_error <= 1'b1;
                        state   <= IDLE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_channel_sequencer.sv
// tb_channel_sequencer: directed scenarios for the channel sequencer with hand-computed expectations.
module tb_channel_sequencer;

    localparam logic [63:0] BASE = 64'hA5A5_0000_0000_0000;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic        start_to = 1'b0;
    logic [7:0]  num_ch = '0;
    logic [7:0]  k_words = '0;
    logic [7:0]  if_words = '0;
    logic        ld_valid = 1'b0;
    logic [63:0] ld_data = '0;
    logic        core_done = 1'b0;
    logic        ofmap_valid = 1'b0;

    logic        ld_ready, write_en, spad_select, reg_clear, route_en, ch_done, busy, done, error;
    logic [7:0]  write_addr, i_addr_end, c;
    logic [63:0] data_in;
    logic [15:0] ofmap_count;

    logic        t_ld_ready, t_write_en, t_spad_select, t_reg_clear, t_route_en, t_ch_done, t_busy, t_done, t_error;
    logic [7:0]  t_write_addr, t_i_addr_end, t_c;
    logic [63:0] t_data_in;
    logic [15:0] t_ofmap_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0, last_wr_cyc = 0, chdone_cyc = 0, done_cyc = 0;
    int n_clear = 0, n_chdone = 0, n_done = 0, n_ready = 0, bad_ready = 0, t_nwr = 0, t_ndone = 0;
    int ddelay = 5, beats = 3, rc = 0;
    logic        prev_route = 1'b0;
    logic [8:0]  wr_q[$];
    logic [63:0] wd_q[$];
    int          rise_q[$];
    logic [7:0]  c_q[$];

    always #5 i_clk = ~i_clk;

    channel_sequencer dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_num_ch(num_ch), .i_k_words(k_words),
        .i_if_words(if_words), .i_ld_valid(ld_valid), .i_ld_data(ld_data), .o_ld_ready(ld_ready),
        .o_write_en(write_en), .o_spad_select(spad_select), .o_write_addr(write_addr), .o_data_in(data_in),
        .o_i_addr_end(i_addr_end), .o_c(c), .o_reg_clear(reg_clear), .o_route_en(route_en),
        .i_core_done(core_done), .i_ofmap_valid(ofmap_valid), .o_ofmap_count(ofmap_count),
        .o_ch_done(ch_done), .o_busy(busy), .o_done(done), .o_error(error)
    );

    channel_sequencer #(.TIMEOUT_CYCLES(16)) dut_to (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(start_to), .i_num_ch(num_ch), .i_k_words(k_words),
        .i_if_words(if_words), .i_ld_valid(ld_valid), .i_ld_data(ld_data), .o_ld_ready(t_ld_ready),
        .o_write_en(t_write_en), .o_spad_select(t_spad_select), .o_write_addr(t_write_addr), .o_data_in(t_data_in),
        .o_i_addr_end(t_i_addr_end), .o_c(t_c), .o_reg_clear(t_reg_clear), .o_route_en(t_route_en),
        .i_core_done(core_done), .i_ofmap_valid(ofmap_valid), .o_ofmap_count(t_ofmap_count),
        .o_ch_done(t_ch_done), .o_busy(t_busy), .o_done(t_done), .o_error(t_error)
    );

    // Event log, sampled on the falling edge when outputs are settled.
    always @(negedge i_clk) begin
        cyc++;
        if (write_en) begin
            wr_q.push_back({spad_select, write_addr});
            wd_q.push_back(data_in);
            last_wr_cyc = cyc;
        end
        if (route_en && !prev_route) begin
            rise_q.push_back(cyc);
            c_q.push_back(c);
        end
        prev_route = route_en;
        if (reg_clear) n_clear++;
        if (ch_done) begin n_chdone++; chdone_cyc = cyc; end
        if (done) begin n_done++; done_cyc = cyc; end
        if (ld_ready) n_ready++;
        if (ld_ready && route_en) bad_ready++;
        if (t_write_en) t_nwr++;
        if (t_done) t_ndone++;
    end

    // Core model: ofmap beats for the first 'beats' ROUTE cycles, done on ROUTE cycle 'ddelay'.
    always @(negedge i_clk) begin
        if (route_en) begin
            rc++;
            ofmap_valid = rc <= beats;
            core_done = rc == ddelay;
        end else begin
            rc = 0;
            ofmap_valid = 1'b0;
            core_done = 1'b0;
        end
    end

    function automatic int first_bad_write(int nch, int k, int ifw);
        int j = 0;
        for (int ch = 0; ch < nch; ch++)
            for (int p = 0; p < 2; p++)
                for (int a = 0; a < (p == 1 ? ifw : k); a++) begin
                    if (j >= wr_q.size() || wr_q[j] !== {p[0], a[7:0]} || wd_q[j] !== BASE + 64'(j))
                        return j;
                    j++;
                end
        return (j == wr_q.size()) ? -1 : j;
    endfunction

    task automatic clear_logs();
        wr_q.delete(); wd_q.delete(); rise_q.delete(); c_q.delete();
        n_clear = 0; n_chdone = 0; n_done = 0; n_ready = 0; bad_ready = 0; t_nwr = 0; t_ndone = 0;
    endtask

    task automatic run_layer(input int nch, input int k, input int ifw, input bit gaps,
                             input int abort_at, input bit poke, output bit done_seen);
        int idx = 0;
        int total = nch * (k + ifw);
        bit hs = 0;
        bit poked = 0;
        @(negedge i_clk);
        clear_logs();
        num_ch = 8'(nch); k_words = 8'(k); if_words = 8'(ifw);
        i_start = 1'b1;
        done_seen = 0;
        for (int n = 0; n < 20000 && !done_seen; n++) begin
            @(negedge i_clk);
            i_start = 1'b0;
            if (done) done_seen = 1;
            if (abort_at > 0 && wr_q.size() >= abort_at) break;
            if (poke && route_en && !poked) begin i_start = 1'b1; poked = 1; end
            if (hs) idx++;
            ld_valid = idx < total && (!gaps || $urandom % 2 == 1);
            ld_data = BASE + 64'(idx);
            hs = ld_valid && ld_ready;
        end
        ld_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (2) @(negedge i_clk);
        checks++;
        if ({ld_ready, write_en, spad_select, write_addr, data_in, i_addr_end, c, reg_clear, route_en,
             ofmap_count, ch_done, busy, done, error} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b ready=%b we=%b err=%b cnt=%0d, required all 0",
                     busy, ld_ready, write_en, error, ofmap_count);
        end
        i_rst = 1'b0;
        @(negedge i_clk); #1;
        checks++;
        if (busy !== 1'b0 || t_busy !== 1'b0 || t_error !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got busy=%b t_busy=%b t_error=%b, required 0 0 0", busy, t_busy, t_error);
        end
    endtask

    task automatic test_basic();
        bit ok;
        int bad;
        ddelay = 5; beats = 3;
        run_layer(1, 9, 100, 0, 0, 0, ok);
        bad = first_bad_write(1, 9, 100);
        checks++; if (!ok) begin failures++; $display("FAIL basic_done got no o_done, required o_done"); end
        checks++; if (wr_q.size() != 109) begin failures++; $display("FAIL basic_wr_count got %0d, required 109", wr_q.size()); end
        checks++; if (bad != -1) begin failures++; $display("FAIL basic_wr_seq first bad write %0d, required none", bad); end
        checks++; if (i_addr_end !== 8'd99) begin failures++; $display("FAIL basic_addr_end got %0d, required 99", i_addr_end); end
        checks++;
        if (rise_q.size() != 1 || rise_q[0] - last_wr_cyc != 2) begin
            failures++;
            $display("FAIL basic_arm_delay got rises=%0d last_wr=%0d, required 1 rise 2 cycles after last write", rise_q.size(), last_wr_cyc);
        end
        checks++; if (n_clear != 1) begin failures++; $display("FAIL basic_reg_clear got %0d, required 1", n_clear); end
        checks++; if (n_chdone != 1) begin failures++; $display("FAIL basic_ch_done got %0d, required 1", n_chdone); end
        checks++; if (n_done != 1) begin failures++; $display("FAIL basic_done_count got %0d, required 1", n_done); end
        checks++; if (done_cyc - chdone_cyc != 1) begin failures++; $display("FAIL basic_done_order got %0d, required 1", done_cyc - chdone_cyc); end
        checks++; if (ofmap_count !== 16'd3) begin failures++; $display("FAIL basic_ofmap got %0d, required 3", ofmap_count); end
        checks++; if (n_ready != 109 || bad_ready != 0) begin failures++; $display("FAIL basic_ready got %0d/%0d, required 109/0", n_ready, bad_ready); end
    endtask

    task automatic test_multi_channel();
        bit ok;
        int bad;
        ddelay = 3; beats = 2;
        run_layer(3, 2, 4, 0, 0, 0, ok);
        bad = first_bad_write(3, 2, 4);
        checks++; if (!ok) begin failures++; $display("FAIL multi_done got no o_done, required o_done"); end
        checks++; if (wr_q.size() != 18 || bad != -1) begin failures++; $display("FAIL multi_wr_seq got %0d writes bad=%0d, required 18 none", wr_q.size(), bad); end
        checks++;
        if (c_q.size() != 3 || c_q[0] !== 8'd0 || c_q[1] !== 8'd1 || c_q[2] !== 8'd2) begin
            failures++;
            $display("FAIL multi_channel_idx got %0d route phases, required c=0,1,2", c_q.size());
        end
        checks++; if (n_chdone != 3) begin failures++; $display("FAIL multi_ch_done got %0d, required 3", n_chdone); end
        checks++; if (n_clear != 1) begin failures++; $display("FAIL multi_reg_clear got %0d, required 1", n_clear); end
        checks++; if (n_done != 1) begin failures++; $display("FAIL multi_done_count got %0d, required 1", n_done); end
        checks++; if (ofmap_count !== 16'd6) begin failures++; $display("FAIL multi_ofmap got %0d, required 6", ofmap_count); end
    endtask

    task automatic test_valid_gaps();
        bit ok;
        int bad;
        ddelay = 4; beats = 1;
        run_layer(2, 5, 7, 1, 0, 0, ok);
        bad = first_bad_write(2, 5, 7);
        checks++; if (!ok) begin failures++; $display("FAIL gaps_done got no o_done, required o_done"); end
        checks++; if (wr_q.size() != 24 || bad != -1) begin failures++; $display("FAIL gaps_wr_seq got %0d writes bad=%0d, required 24 none", wr_q.size(), bad); end
        checks++; if (bad_ready != 0) begin failures++; $display("FAIL gaps_ready_in_route got %0d, required 0", bad_ready); end
    endtask

    task automatic test_ofmap_64();
        bit ok;
        ddelay = 64; beats = 64;
        run_layer(1, 1, 1, 0, 0, 0, ok);
        checks++; if (!ok || ofmap_count !== 16'd64) begin failures++; $display("FAIL ofmap64 got done=%0b count=%0d, required 1 64", ok, ofmap_count); end
    endtask

    task automatic test_timeout();
        int route_cycles = 0;
        bit seen = 0;
        @(negedge i_clk);
        clear_logs();
        num_ch = 8'd1; k_words = 8'd0; if_words = 8'd0;
        start_to = 1'b1;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge i_clk);
            start_to = 1'b0;
            if (t_error) seen = 1;
            else if (t_route_en) route_cycles++;
        end
        #1;
        checks++; if (!seen) begin failures++; $display("FAIL timeout_error got o_error=0, required 1"); end
        checks++; if (route_cycles != 16) begin failures++; $display("FAIL timeout_route_cycles got %0d, required 16", route_cycles); end
        checks++; if (t_route_en !== 1'b0 || t_busy !== 1'b0) begin failures++; $display("FAIL timeout_idle got route=%b busy=%b, required 0 0", t_route_en, t_busy); end
        checks++; if (t_ndone != 0 || t_nwr != 0) begin failures++; $display("FAIL timeout_no_done got done=%0d writes=%0d, required 0 0", t_ndone, t_nwr); end
        checks++; if (t_i_addr_end !== 8'd0) begin failures++; $display("FAIL timeout_addr_end got %0d, required 0", t_i_addr_end); end
        repeat (3) @(negedge i_clk);
        checks++; if (t_error !== 1'b1) begin failures++; $display("FAIL timeout_sticky got %b, required 1", t_error); end
        num_ch = 8'd0;
        start_to = 1'b1;
        @(negedge i_clk);
        start_to = 1'b0;
        checks++; if (t_error !== 1'b0) begin failures++; $display("FAIL timeout_clear got %b, required 0", t_error); end
    endtask

    task automatic test_reset_mid_load();
        bit ok;
        int bad;
        ddelay = 3; beats = 1;
        run_layer(1, 3, 20, 0, 8, 0, ok);
        i_rst = 1'b1;
        #1;
        checks++;
        if ({ld_ready, write_en, spad_select, write_addr, data_in, i_addr_end, c, reg_clear, route_en,
             ofmap_count, ch_done, busy, done, error} !== '0) begin
            failures++;
            $display("FAIL rst_mid_outputs got busy=%b ready=%b we=%b addr_end=%0d, required all 0",
                     busy, ld_ready, write_en, i_addr_end);
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        run_layer(1, 3, 20, 0, 0, 0, ok);
        bad = first_bad_write(1, 3, 20);
        checks++; if (!ok || wr_q.size() != 23 || bad != -1) begin failures++; $display("FAIL rst_mid_restart got done=%0b writes=%0d bad=%0d, required 1 23 none", ok, wr_q.size(), bad); end
    endtask

    task automatic test_start_while_busy();
        bit ok;
        ddelay = 6; beats = 2;
        run_layer(1, 2, 2, 0, 0, 1, ok);
        checks++; if (!ok || n_done != 1 || n_chdone != 1) begin failures++; $display("FAIL busy_start_layer got done=%0d ch_done=%0d, required 1 1", n_done, n_chdone); end
        repeat (4) @(negedge i_clk);
        #1;
        checks++; if (busy !== 1'b0 || n_clear != 1) begin failures++; $display("FAIL busy_start_ignored got busy=%b clears=%0d, required 0 1", busy, n_clear); end
    endtask

    task automatic test_num_ch_zero();
        @(negedge i_clk);
        clear_logs();
        num_ch = 8'd0; k_words = 8'd3; if_words = 8'd3;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL zero_ch_first got done=%b busy=%b, required 0 1", done, busy); end
        @(negedge i_clk);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL zero_ch_done got %b, required 1", done); end
        @(negedge i_clk);
        #1;
        checks++; if (done !== 1'b0 || busy !== 1'b0 || wr_q.size() != 0) begin failures++; $display("FAIL zero_ch_after got done=%b busy=%b writes=%0d, required 0 0 0", done, busy, wr_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_multi_channel();
        test_valid_gaps();
        test_ofmap_64();
        test_timeout();
        test_reset_mid_load();
        test_start_while_busy();
        test_num_ch_zero();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got no finish, required finish before time limit");
        $fatal(1);
    end

endmodule
